// File: rtl/alu_lanes_pipe.sv
// alu_lanes_pkg : operation codes and the default FU operand bundle.
// alu_lanes_pipe: NrLanes-wide ALU cluster with one result register stage,
//                 same-cycle (bundle) and previous-cycle forwarding,
//                 standalone popcount and illegal-bypass detection.
package alu_lanes_pkg;
    localparam int unsigned DEF_XLEN          = 64;
    localparam int unsigned DEF_TRANS_ID_BITS = 3;

    typedef enum logic [4:0] {
        ADD   = 5'd0,  SUB  = 5'd1,  XORL = 5'd2,  ORL  = 5'd3,
        ANDL  = 5'd4,  SLL  = 5'd5,  SRL  = 5'd6,  SRA  = 5'd7,
        SLTS  = 5'd8,  SLTU = 5'd9,  EQ   = 5'd10, NE   = 5'd11,
        LTS   = 5'd12, LTU  = 5'd13, GES  = 5'd14, GEU  = 5'd15,
        CPOP  = 5'd16, CPOPW = 5'd17
    } fu_op_t;

    localparam int unsigned NR_OPS = 18;

    typedef struct packed {
        fu_op_t                         operation;
        logic [DEF_XLEN-1:0]            operand_a;
        logic [DEF_XLEN-1:0]            operand_b;
        logic [DEF_TRANS_ID_BITS-1:0]   trans_id;
    } fu_data_t;
endpackage

module alu_lanes_pipe
    import alu_lanes_pkg::*;
#(
    parameter int unsigned XLEN           = alu_lanes_pkg::DEF_XLEN,
    parameter int unsigned TRANS_ID_BITS  = alu_lanes_pkg::DEF_TRANS_ID_BITS,
    parameter bit          RVZCB          = 1'b1,
    parameter type         fu_data_t      = alu_lanes_pkg::fu_data_t,
    parameter int unsigned NrLanes        = 2,
    parameter bit          StandaloneCpop = 1'b1,
    parameter int unsigned LaneIdxW       = (NrLanes > 1) ? $clog2(NrLanes) : 1
)(
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic [NrLanes-1:0]                        valid_i,
    input  fu_data_t [NrLanes-1:0]                    fu_data_i,
    input  logic [NrLanes-1:0][4+2*LaneIdxW-1:0]      bypass_i,
    output logic [NrLanes-1:0]                        valid_o,
    output logic [NrLanes-1:0][XLEN-1:0]              result_o,
    output logic [NrLanes-1:0][TRANS_ID_BITS-1:0]     trans_id_o,
    output logic                                      branch_res_o,
    output logic                                      illegal_bypass_o
);

    localparam int unsigned BP_W     = 4 + 2 * LaneIdxW;
    localparam int unsigned SH_W     = $clog2(XLEN);
    localparam int unsigned PC_W     = $clog2(XLEN) + 1;
    localparam bit          IS_XLEN64 = (XLEN == 64);
    localparam bit          USE_CPOP = StandaloneCpop && RVZCB;
    // CPOPW only looks at the low word on RV64; on RV32 the word is the whole operand.
    localparam logic [XLEN-1:0] WORD_MASK = IS_XLEN64 ? XLEN'(64'h0000_0000_FFFF_FFFF)
                                                      : {XLEN{1'b1}};

    localparam logic [1:0] SRC_REG    = 2'd0;
    localparam logic [1:0] SRC_BUNDLE = 2'd1;
    localparam logic [1:0] SRC_PREV   = 2'd2;

    function automatic logic [PC_W-1:0] popcount(input logic [XLEN-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < XLEN; k++) begin
            cnt = cnt + {{(PC_W-1){1'b0}}, v[k]};
        end
        return cnt;
    endfunction

    function automatic logic is_branch(input fu_op_t op);
        return op inside {EQ, NE, LTS, LTU, GES, GEU};
    endfunction

    function automatic logic compare(input fu_op_t op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic r;
        case (op)
            EQ:      r = (a == b);
            NE:      r = (a != b);
            LTS:     r = ($signed(a) <  $signed(b));
            LTU:     r = (a <  b);
            GES:     r = ($signed(a) >= $signed(b));
            GEU:     r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Branch compares carry no data result; their outcome leaves on branch_res_o.
    function automatic logic [XLEN-1:0] alu(input fu_op_t op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            XORL:    r = a ^ b;
            ORL:     r = a | b;
            ANDL:    r = a & b;
            SLL:     r = a << b[SH_W-1:0];
            SRL:     r = a >> b[SH_W-1:0];
            SRA:     r = $unsigned($signed(a) >>> b[SH_W-1:0]);
            SLTS:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            SLTU:    r = {{(XLEN-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [NrLanes-1:0][XLEN-1:0]          lane_res_s;
    logic [NrLanes-1:0][XLEN-1:0]          lane_a_s;
    logic [NrLanes-1:0][XLEN-1:0]          lane_b_s;
    logic                                  illegal_s;
    logic                                  branch_s;

    logic [NrLanes-1:0]                    valid_r;
    logic [NrLanes-1:0][XLEN-1:0]          result_r;
    logic [NrLanes-1:0][TRANS_ID_BITS-1:0] trans_id_r;
    logic                                  branch_r;
    logic                                  illegal_r;

    // Resolve operand sources lane by lane, lowest first, so bundle forwarding sees final results.
    always_comb begin
        logic [BP_W-1:0]     bp;
        logic [1:0]          src  [2];
        logic [LaneIdxW-1:0] sel  [2];
        logic [XLEN-1:0]     regv [2];
        logic [XLEN-1:0]     opnd [2];
        logic [XLEN-1:0]     fwd;
        logic                legal;
        fu_op_t              op;

        lane_res_s = '0;
        lane_a_s   = '0;
        lane_b_s   = '0;
        illegal_s  = 1'b0;
        for (int i = 0; i < NrLanes; i++) begin
            bp      = bypass_i[i];
            op      = fu_data_i[i].operation;
            src[0]  = bp[BP_W-1 -: 2];
            sel[0]  = bp[BP_W-3 -: LaneIdxW];
            src[1]  = bp[LaneIdxW+1 -: 2];
            sel[1]  = bp[LaneIdxW-1:0];
            regv[0] = fu_data_i[i].operand_a;
            regv[1] = fu_data_i[i].operand_b;
            for (int k = 0; k < 2; k++) begin
                case (src[k])
                    SRC_REG: begin
                        legal = 1'b1;
                        fwd   = regv[k];
                    end
                    SRC_BUNDLE: begin
                        legal = (int'(sel[k]) < i) && valid_i[sel[k]];
                        fwd   = lane_res_s[sel[k]];
                    end
                    SRC_PREV: begin
                        legal = (int'(sel[k]) < int'(NrLanes)) && valid_r[sel[k]];
                        fwd   = result_r[sel[k]];
                    end
                    default: begin
                        legal = 1'b0;
                        fwd   = regv[k];
                    end
                endcase
                if (legal) begin
                    opnd[k] = fwd;
                end else begin
                    opnd[k]   = regv[k];
                    illegal_s = illegal_s | valid_i[i];
                end
            end
            lane_a_s[i] = opnd[0];
            lane_b_s[i] = opnd[1];
            if (USE_CPOP && (op == CPOP)) begin
                lane_res_s[i] = XLEN'(popcount(opnd[0]));
            end else if (USE_CPOP && (op == CPOPW)) begin
                lane_res_s[i] = XLEN'(popcount(opnd[0] & WORD_MASK));
            end else begin
                lane_res_s[i] = alu(op, opnd[0], opnd[1]);
            end
        end
        branch_s = is_branch(fu_data_i[0].operation)
                 & compare(fu_data_i[0].operation, lane_a_s[0], lane_b_s[0]);
    end

    // Result stage: valid follows issue unless flushed; data loads only for surviving lanes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r    <= '0;
            result_r   <= '0;
            trans_id_r <= '0;
            branch_r   <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            valid_r   <= valid_i & ~{NrLanes{flush_i}};
            illegal_r <= illegal_s;
            for (int i = 0; i < NrLanes; i++) begin
                if (valid_i[i] && !flush_i) begin
                    result_r[i]   <= lane_res_s[i];
                    trans_id_r[i] <= fu_data_i[i].trans_id;
                end
            end
            if (valid_i[0] && !flush_i) begin
                branch_r <= branch_s;
            end
        end
    end

    assign valid_o          = valid_r;
    assign result_o         = result_r;
    assign trans_id_o       = trans_id_r;
    assign branch_res_o     = branch_r;
    assign illegal_bypass_o = illegal_r;

endmodule

// File: tb/tb_alu_lanes_pipe.sv
// Bench for alu_lanes_pipe: directed scenarios followed by randomized traffic,
// all checked against an operation-level reference model of the cluster.
module tb_alu_lanes_pipe;
    import alu_lanes_pkg::*;

    localparam int NL = 3;
    localparam int LW = 2;
    localparam int BW = 4 + 2 * LW;
    localparam int XL = 64;
    localparam int TB = 3;

    logic                      clk_i;
    logic                      rst_ni;
    logic                      flush_i;
    logic [NL-1:0]             valid_i;
    fu_data_t [NL-1:0]         fu_data_i;
    logic [NL-1:0][BW-1:0]     bypass_i;
    logic [NL-1:0]             valid_o;
    logic [NL-1:0][XL-1:0]     result_o;
    logic [NL-1:0][TB-1:0]     trans_id_o;
    logic                      branch_res_o;
    logic                      illegal_bypass_o;

    alu_lanes_pipe #(
        .XLEN(XL), .TRANS_ID_BITS(TB), .RVZCB(1'b1), .fu_data_t(fu_data_t),
        .NrLanes(NL), .StandaloneCpop(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .fu_data_i(fu_data_i), .bypass_i(bypass_i), .valid_o(valid_o),
        .result_o(result_o), .trans_id_o(trans_id_o), .branch_res_o(branch_res_o),
        .illegal_bypass_o(illegal_bypass_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // stimulus for the next cycle
    fu_op_t      t_op  [NL];
    logic [63:0] t_a   [NL];
    logic [63:0] t_b   [NL];
    logic [2:0]  t_tid [NL];
    logic [1:0]  t_s1  [NL];
    logic [1:0]  t_l1  [NL];
    logic [1:0]  t_s2  [NL];
    logic [1:0]  t_l2  [NL];
    logic [NL-1:0] t_v;
    logic        t_flush;

    // reference model: what the outputs should show right now
    logic [NL-1:0] m_valid;
    logic [63:0]   m_res [NL];
    logic [2:0]    m_tid [NL];
    logic          m_br;
    logic          m_ill;
    logic [63:0]   cur_res [NL];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [63:0] ref_result(fu_op_t op, logic [63:0] a, logic [63:0] b);
        case (op)
            ADD:   return a + b;
            SUB:   return a - b;
            XORL:  return a ^ b;
            ORL:   return a | b;
            ANDL:  return a & b;
            SLL:   return a << b[5:0];
            SRL:   return a >> b[5:0];
            SRA:   return 64'($signed(a) >>> b[5:0]);
            SLTS:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            SLTU:  return (a < b) ? 64'd1 : 64'd0;
            CPOP:  return 64'($countones(a));
            CPOPW: return 64'($countones(a[31:0]));
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_branch(fu_op_t op, logic [63:0] a, logic [63:0] b);
        case (op)
            EQ:  return a == b;
            NE:  return a != b;
            LTS: return $signed(a) < $signed(b);
            LTU: return a < b;
            GES: return $signed(a) >= $signed(b);
            GEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Returns 1 when the select is usable; val gets the operand actually used.
    function automatic bit pick(int i, logic [1:0] s, logic [1:0] l, logic [63:0] regv,
                                output logic [63:0] val);
        val = regv;
        if (s == 2'd0) return 1'b1;
        if (s == 2'd1 && int'(l) < i && t_v[l]) begin
            val = cur_res[l];
            return 1'b1;
        end
        if (s == 2'd2 && int'(l) < NL && m_valid[l]) begin
            val = m_res[l];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 64'(valid_o), 64'(m_valid));
        for (int i = 0; i < NL; i++) begin
            check($sformatf("%s.res%0d", tag, i), result_o[i], m_res[i]);
            check($sformatf("%s.tid%0d", tag, i), 64'(trans_id_o[i]), 64'(m_tid[i]));
        end
        check({tag, ".branch"}, 64'(branch_res_o), 64'(m_br));
        check({tag, ".illegal"}, 64'(illegal_bypass_o), 64'(m_ill));
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NL; i++) begin
            t_op[i] = ADD; t_a[i] = 64'd0; t_b[i] = 64'd0; t_tid[i] = 3'd0;
            t_s1[i] = 2'd0; t_l1[i] = 2'd0; t_s2[i] = 2'd0; t_l2[i] = 2'd0;
        end
        t_v = '0;
        t_flush = 1'b0;
    endtask

    task automatic set_lane(int i, fu_op_t op, logic [63:0] a, logic [63:0] b, logic [2:0] tid);
        t_op[i] = op; t_a[i] = a; t_b[i] = b; t_tid[i] = tid;
        t_v[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_valid = '0; m_br = 1'b0; m_ill = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_res[i] = 64'd0; m_tid[i] = 3'd0;
        end
    endtask

    // Predict, drive one cycle, advance the model, compare everything.
    task automatic step(input string tag);
        logic [63:0] oa, ob, a0, b0;
        logic ill;
        bit ok;
        ill = 1'b0; a0 = 64'd0; b0 = 64'd0;
        for (int i = 0; i < NL; i++) cur_res[i] = 64'd0;
        for (int i = 0; i < NL; i++) begin
            ok = pick(i, t_s1[i], t_l1[i], t_a[i], oa);
            if (!ok && t_v[i]) ill = 1'b1;
            ok = pick(i, t_s2[i], t_l2[i], t_b[i], ob);
            if (!ok && t_v[i]) ill = 1'b1;
            cur_res[i] = ref_result(t_op[i], oa, ob);
            if (i == 0) begin a0 = oa; b0 = ob; end
        end
        valid_i = t_v;
        flush_i = t_flush;
        for (int i = 0; i < NL; i++) begin
            fu_data_i[i].operation = t_op[i];
            fu_data_i[i].operand_a = t_a[i];
            fu_data_i[i].operand_b = t_b[i];
            fu_data_i[i].trans_id  = t_tid[i];
            bypass_i[i] = {t_s1[i], t_l1[i], t_s2[i], t_l2[i]};
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (t_v[i] && !t_flush) begin
                m_res[i] = cur_res[i];
                m_tid[i] = t_tid[i];
            end
        end
        if (t_v[0] && !t_flush) m_br = ref_branch(t_op[0], a0, b0);
        m_valid = t_v & ~{NL{t_flush}};
        m_ill   = ill;
        check_outputs(tag);
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_lanes();
        valid_i = '0; flush_i = 1'b0; fu_data_i = '0; bypass_i = '0;
        model_reset();
        #12;
        check_outputs("reset");
        rst_ni = 1'b1;

        // all lanes from the register file
        clear_lanes();
        set_lane(0, ADD, 64'd5, 64'd7, 3'd1);
        set_lane(1, SUB, 64'd10, 64'd3, 3'd2);
        set_lane(2, XORL, 64'hF0, 64'h0F, 3'd3);
        step("all_reg");
        check("all_reg.k0", result_o[0], 64'd12);
        check("all_reg.k1", result_o[1], 64'd7);
        check("all_reg.k2", result_o[2], 64'hFF);

        // chained same-cycle forwarding 0 -> 1 -> 2
        clear_lanes();
        set_lane(0, ADD, 64'd1, 64'd1, 3'd4);
        set_lane(1, ADD, 64'd99, 64'd3, 3'd5); t_s1[1] = 2'd1; t_l1[1] = 2'd0;
        set_lane(2, ADD, 64'd77, 64'd4, 3'd6); t_s1[2] = 2'd1; t_l1[2] = 2'd1;
        step("chain");
        check("chain.k2", result_o[2], 64'd9);
        check("chain.kill", 64'(illegal_bypass_o), 64'd0);

        // cross-cycle forwarding, then flush makes PREV illegal
        clear_lanes();
        set_lane(1, ADD, 64'd60, 64'd40, 3'd1);
        step("prev_src");
        clear_lanes();
        set_lane(0, ADD, 64'd1, 64'd55, 3'd2); t_s2[0] = 2'd2; t_l2[0] = 2'd1;
        set_lane(1, ADD, 64'd60, 64'd40, 3'd3);
        step("prev_use");
        check("prev_use.k0", result_o[0], 64'd101);
        t_flush = 1'b1;
        step("flush_prev");
        check("flush_prev.kv", 64'(valid_o), 64'd0);
        clear_lanes();
        set_lane(0, ADD, 64'd1, 64'd5, 3'd7); t_s2[0] = 2'd2; t_l2[0] = 2'd1;
        step("prev_after_flush");
        check("prev_after_flush.k0", result_o[0], 64'd6);
        check("prev_after_flush.kill", 64'(illegal_bypass_o), 64'd1);

        // bundle from a higher lane is illegal, pulse then clear
        clear_lanes();
        set_lane(0, ADD, 64'd20, 64'd2, 3'd1); t_s1[0] = 2'd1; t_l1[0] = 2'd1;
        set_lane(1, ADD, 64'd7, 64'd7, 3'd2);
        step("bad_bundle");
        check("bad_bundle.k0", result_o[0], 64'd22);
        clear_lanes();
        set_lane(0, ADD, 64'd2, 64'd2, 3'd3);
        set_lane(1, SRA, 64'h8000_0000_0000_0000, 64'd4, 3'd4);
        step("pulse_end");
        check("pulse_end.kill", 64'(illegal_bypass_o), 64'd0);

        // popcount
        clear_lanes();
        set_lane(1, CPOPW, 64'hFFFF_FFFF_0000_00FF, 64'd0, 3'd5);
        step("cpopw");
        check("cpopw.k1", result_o[1], 64'd8);
        set_lane(1, CPOP, 64'hFFFF_FFFF_0000_00FF, 64'd0, 3'd6);
        step("cpop");
        check("cpop.k1", result_o[1], 64'd40);

        // flush with lanes issuing: valid drops, data holds
        clear_lanes();
        set_lane(0, ADD, 64'd9, 64'd9, 3'd1);
        set_lane(1, ADD, 64'd8, 64'd8, 3'd2);
        set_lane(2, ADD, 64'd7, 64'd7, 3'd3);
        t_flush = 1'b1;
        step("flush_all");
        check("flush_all.kv", 64'(valid_o), 64'd0);
        check("flush_all.k1", result_o[1], 64'd40);

        // lane-0 branch compare
        clear_lanes();
        set_lane(0, EQ, 64'd5, 64'd5, 3'd1);
        step("br_eq");
        check("br_eq.k", 64'(branch_res_o), 64'd1);
        set_lane(0, LTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd2);
        step("br_lts");
        check("br_lts.k", 64'(branch_res_o), 64'd1);
        set_lane(0, GEU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3);
        step("br_geu");
        check("br_geu.k", 64'(branch_res_o), 64'd0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NL; i++) begin
                t_op[i]  = fu_op_t'($urandom_range(0, NR_OPS - 1));
                t_a[i]   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15))
                                                      : {$urandom, $urandom};
                t_b[i]   = {$urandom, $urandom};
                t_tid[i] = 3'($urandom_range(0, 7));
                t_s1[i]  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
                t_l1[i]  = 2'($urandom_range(0, 3));
                t_s2[i]  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
                t_l2[i]  = 2'($urandom_range(0, 3));
            end
            t_v     = 3'($urandom_range(0, 7));
            t_flush = ($urandom_range(0, 7) == 0);
            step($sformatf("rnd%0d", n));
        end

        // asynchronous reset in the middle of a cycle
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        #1;
        rst_ni = 1'b1;
        clear_lanes();
        set_lane(0, ADD, 64'd3, 64'd4, 3'd2); t_s2[0] = 2'd2; t_l2[0] = 2'd0;
        step("post_reset");
        check("post_reset.k0", result_o[0], 64'd7);
        check("post_reset.kill", 64'(illegal_bypass_o), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
